// File: rtl/fe_fifo_reader.sv
// fe_fifo_reader
//   Read side of the front-end capture FIFO, clocked on cwusb_clk.
//   - Pops FWFT entries {cmd[1:0], time, data} and serializes each entry into
//     a byte stream with a valid/ready handshake for the USB bulk-read path.
//   - Keeps byte/entry counters and a sticky bad-command flag so software can
//     check readout integrity.
//   - Entries are loaded back-to-back: the next entry is popped in the same
//     cycle the final byte of the current one is accepted, so there is no bubble.
//
// Ports
//   cwusb_clk, reset_i   clock, asynchronous active-high reset
//   I_fifo_dout/empty    FWFT FIFO head entry and empty flag
//   O_fifo_rd            pop strobe (combinational, same cycle as load)
//   I_flush              abort the held entry and return to idle
//   O_byte/_valid        serialized byte stream, I_byte_ready accepts it
//   O_busy               an entry is held or being sent
//   O_bytes_sent         accepted bytes since last clear
//   O_entries_read       popped entries since last clear
//   I_clear_counts       synchronous clear of counters, O_bad_cmd, O_checksum
//   O_bad_cmd            sticky: a reserved command code was popped
//   O_checksum           running XOR of accepted bytes
//
// Build option
//   FE_READER_CHECKSUM_EN  builds the O_checksum accumulator; when undefined
//                          O_checksum is tied to 8'h00.
module fe_fifo_reader #(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pDATA_WIDTH            = 8,
  parameter int pCOUNT_WIDTH           = 24,
  // Command codes of the front-end FIFO (defines_pw.v); 2'b11 is reserved.
  parameter logic [1:0] pCMD_DATA = 2'b00,
  parameter logic [1:0] pCMD_TIME = 2'b01,
  parameter logic [1:0] pCMD_STAT = 2'b10
) (
  input  logic                                        cwusb_clk,
  input  logic                                        reset_i,
  input  logic [2+pTIMESTAMP_FULL_WIDTH+pDATA_WIDTH-1:0] I_fifo_dout,
  input  logic                                        I_fifo_empty,
  output logic                                        O_fifo_rd,
  input  logic                                        I_flush,
  output logic [7:0]                                  O_byte,
  output logic                                        O_byte_valid,
  input  logic                                        I_byte_ready,
  output logic                                        O_busy,
  output logic [pCOUNT_WIDTH-1:0]                     O_bytes_sent,
  output logic [pCOUNT_WIDTH-1:0]                     O_entries_read,
  input  logic                                        I_clear_counts,
  output logic                                        O_bad_cmd,
  output logic [7:0]                                  O_checksum
);

  localparam int ENTRY_W = 2 + pTIMESTAMP_FULL_WIDTH + pDATA_WIDTH;

  // State names the byte currently presented on O_byte.
  typedef enum logic [1:0] {IDLE, HDR, B1, B2} state_t;

  state_t               state_q;
  logic [ENTRY_W-1:0]   hold_q;

  logic [1:0]                       in_cmd, hold_cmd;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] in_time, hold_time;
  logic [pDATA_WIDTH-1:0]           hold_data;
  logic                             accept, last_acc, load, in_rsv;

  assign in_cmd    = I_fifo_dout[ENTRY_W-1 -: 2];
  assign in_time   = I_fifo_dout[pDATA_WIDTH +: pTIMESTAMP_FULL_WIDTH];
  assign hold_cmd  = hold_q[ENTRY_W-1 -: 2];
  assign hold_time = hold_q[pDATA_WIDTH +: pTIMESTAMP_FULL_WIDTH];
  assign hold_data = hold_q[pDATA_WIDTH-1:0];

  assign in_rsv = !((in_cmd == pCMD_DATA) || (in_cmd == pCMD_STAT) ||
                    (in_cmd == pCMD_TIME));

  assign accept   = O_byte_valid & I_byte_ready;
  // Final byte of the held entry accepted: B1 for 2-byte entries, B2 for TIME.
  assign last_acc = accept & (((state_q == B1) && (hold_cmd != pCMD_TIME)) ||
                              (state_q == B2));
  // Flush and reset both suppress the pop so nothing is lost from the FIFO.
  assign load      = !I_fifo_empty && !I_flush && !reset_i &&
                     ((state_q == IDLE) || last_acc);
  assign O_fifo_rd = load;
  assign O_busy    = (state_q != IDLE);

  // Header byte: TIME carries only the command; DATA/STAT also carry the
  // short timestamp, left-aligned under the command and zero padded.
  function automatic logic [7:0] hdr_of(input logic [1:0] c,
                                        input logic [pTIMESTAMP_FULL_WIDTH-1:0] t);
    logic [7:0] h;
    h      = 8'h00;
    h[7:6] = c;
    if (c != pCMD_TIME) h[5 -: pTIMESTAMP_SHORT_WIDTH] = t[pTIMESTAMP_SHORT_WIDTH-1:0];
    return h;
  endfunction

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      O_byte         <= 8'h00;
      O_byte_valid   <= 1'b0;
      O_bytes_sent   <= '0;
      O_entries_read <= '0;
      O_bad_cmd      <= 1'b0;
    end else begin
      // Counters and sticky flag; a coincident clear wins over increments.
      if (I_clear_counts) begin
        O_bytes_sent   <= '0;
        O_entries_read <= '0;
        O_bad_cmd      <= 1'b0;
      end else begin
        if (accept)          O_bytes_sent   <= O_bytes_sent + pCOUNT_WIDTH'(1);
        if (load)            O_entries_read <= O_entries_read + pCOUNT_WIDTH'(1);
        if (load && in_rsv)  O_bad_cmd      <= 1'b1;
      end

      if (I_flush) begin
        state_q      <= IDLE;
        O_byte_valid <= 1'b0;
        hold_q       <= '0;
      end else if (load) begin
        hold_q <= I_fifo_dout;
        if (in_rsv) begin
          // Reserved entries are swallowed; IDLE lets the next one load at once.
          state_q      <= IDLE;
          O_byte_valid <= 1'b0;
        end else begin
          state_q      <= HDR;
          O_byte_valid <= 1'b1;
          O_byte       <= hdr_of(in_cmd, in_time);
        end
      end else if (accept) begin
        case (state_q)
          HDR: begin
            state_q <= B1;
            O_byte  <= (hold_cmd == pCMD_TIME) ? hold_time[15:8] : hold_data[7:0];
          end
          B1: begin
            if (hold_cmd == pCMD_TIME) begin
              state_q <= B2;
              O_byte  <= hold_time[7:0];
            end else begin
              state_q      <= IDLE;
              O_byte_valid <= 1'b0;
            end
          end
          default: begin
            state_q      <= IDLE;
            O_byte_valid <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FE_READER_CHECKSUM_EN
  logic [7:0] csum_q;
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i)             csum_q <= 8'h00;
    else if (I_clear_counts) csum_q <= 8'h00;
    else if (accept)         csum_q <= csum_q ^ O_byte;
  end
  assign O_checksum = csum_q;
`else
  assign O_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_fe_fifo_reader.sv
// Scoreboard bench for fe_fifo_reader: a small FWFT FIFO model feeds the DUT,
// expected bytes are queued when entries are written and compared as the
// DUT's bytes are accepted.
module tb_fe_fifo_reader;
  localparam logic [1:0] C_DATA = 2'b00, C_TIME = 2'b01, C_STAT = 2'b10, C_RSV = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] fifo_dout;
  logic        fifo_empty, fifo_rd, flush, ready, clr_cnt;
  logic [7:0]  obyte, csum;
  logic        ovalid, busy, bad;
  logic [23:0] bytes_sent, entries;

  always #5 clk = ~clk;

  fe_fifo_reader dut (
    .cwusb_clk(clk), .reset_i(rst), .I_fifo_dout(fifo_dout), .I_fifo_empty(fifo_empty),
    .O_fifo_rd(fifo_rd), .I_flush(flush), .O_byte(obyte), .O_byte_valid(ovalid),
    .I_byte_ready(ready), .O_busy(busy), .O_bytes_sent(bytes_sent),
    .O_entries_read(entries), .I_clear_counts(clr_cnt), .O_bad_cmd(bad),
    .O_checksum(csum)
  );

  // FWFT FIFO model
  logic [25:0] fmem [0:63];
  int wp = 0, rp = 0;
  assign fifo_empty = (wp == rp);
  assign fifo_dout  = fmem[rp[5:0]];
  always @(posedge clk) if (fifo_rd) rp <= rp + 1;

  typedef struct { logic [7:0] b; bit last; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  logic [7:0] cs_model = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
    exp_t e;
    case (c)
      C_TIME: begin
        e.b = {c, 6'b0};  e.last = 0; exp_q.push_back(e);
        e.b = t[15:8];    e.last = 0; exp_q.push_back(e);
        e.b = t[7:0];     e.last = 1; exp_q.push_back(e);
      end
      C_RSV: ;
      default: begin
        e.b = {c, t[2:0], 3'b000}; e.last = 0; exp_q.push_back(e);
        e.b = d;                   e.last = 1; exp_q.push_back(e);
      end
    endcase
  endtask

  task automatic push_entry(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
    fmem[wp[5:0]] = {c, t, d};
    wp++;
    push_exp(c, t, d);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    clr_cnt = 1; tick(); clr_cnt = 0; cs_model = 8'h00;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (exp_q.size() == 0 && rp == wp && !busy) done = 1;
      else tick();
    end
    if (!done) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_valid(input string tag);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (ovalid) done = 1;
      else tick();
    end
    if (!done) check({tag, "_valid_timeout"}, 1, 0);
  endtask

  // Monitor: compare accepted bytes and check pops line up with entry ends.
  exp_t me;
  bit   macc, mlast;
  always @(negedge clk) begin
    if (!rst) begin
      macc  = ovalid & ready;
      mlast = 0;
      if (macc) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'h0, obyte}, 32'hFFFF_FFFF);
        else begin
          me = exp_q.pop_front();
          check("byte", {24'h0, obyte}, {24'h0, me.b});
          mlast    = me.last;
          cs_model = cs_model ^ me.b;
        end
      end
      if (fifo_rd) check("rd_align", 32'(!busy || (macc && mlast)), 1);
    end
  end

  initial begin
    exp_t e;
    int n;
    rst = 1; flush = 0; ready = 0; clr_cnt = 0;
    #3;
    check("rst_valid", 32'(ovalid), 0);
    check("rst_byte", 32'(obyte), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd", 32'(fifo_rd), 0);
    check("rst_counts", {8'h0, bytes_sent} | {8'h0, entries}, 0);
    check("rst_bad", 32'(bad), 0);
    check("rst_csum", 32'(csum), 0);
    tick(); tick();
    rst = 0;

    // DATA entry, always ready
    ready = 1;
    push_entry(C_DATA, 16'd5, 8'hA7);
    wait_drain("t1");
    check("t1_entries", 32'(entries), 1);
    check("t1_bytes", 32'(bytes_sent), 2);
    check("t1_valid_idle", 32'(ovalid), 0);
    push_entry(C_STAT, 16'h0002, 8'hE1);
    wait_drain("t1s");
    check("t1s_entries", 32'(entries), 2);
    check("t1s_bytes", 32'(bytes_sent), 4);

    // TIME then DATA back to back: five bytes in five cycles
    clr();
    push_entry(C_TIME, 16'h1234, 8'h00);
    push_entry(C_DATA, 16'h0003, 8'h5A);
    wait_valid("t2");
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
    check("t2_no_bubble", n, 5);
    wait_drain("t2");
    check("t2_entries", 32'(entries), 2);
    check("t2_bytes", 32'(bytes_sent), 5);

    // Back-pressure on the 8'h12 byte
    clr();
    ready = 0;
    push_entry(C_TIME, 16'h1234, 8'h00);
    push_entry(C_DATA, 16'h0006, 8'h77);
    wait_valid("t3");
    ready = 1; tick(); ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_hold_byte", 32'(obyte), 32'h12);
      check("t3_hold_valid", 32'(ovalid), 1);
      check("t3_no_pop", 32'(fifo_rd), 0);
    end
    tick();
    ready = 1;
    wait_drain("t3");
    check("t3_entries", 32'(entries), 2);
    check("t3_bytes", 32'(bytes_sent), 5);

    // Reserved then DATA
    clr();
    push_entry(C_RSV, 16'hFFFF, 8'hFF);
    push_entry(C_DATA, 16'h0001, 8'hC3);
    wait_drain("t4");
    check("t4_bad", 32'(bad), 1);
    check("t4_entries", 32'(entries), 2);
    check("t4_bytes", 32'(bytes_sent), 2);
    clr();
    check("t4_clr_bad", 32'(bad), 0);
    check("t4_clr_entries", 32'(entries), 0);

    // Flush while in B1
    ready = 0;
    push_entry(C_DATA, 16'h0002, 8'h99);
    wait_valid("t5");
    ready = 1; tick(); ready = 0;
    push_entry(C_DATA, 16'h0007, 8'h3C);
    flush = 1;
    @(negedge clk);
    check("t5_flush_rd", 32'(fifo_rd), 0);
    tick();
    flush = 0;
    check("t5_valid", 32'(ovalid), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_entries", 32'(entries), 1);
    check("t5_bytes", 32'(bytes_sent), 1);
    e = exp_q.pop_front();   // flushed data byte never appears
    ready = 1;
    wait_drain("t5");
    check("t5_after_entries", 32'(entries), 2);
    check("t5_after_bytes", 32'(bytes_sent), 3);

    // Async reset mid-entry with a further entry waiting in the FIFO
    ready = 0;
    push_entry(C_DATA, 16'h0001, 8'h11);
    push_entry(C_DATA, 16'h0004, 8'h22);
    wait_valid("t6");
    #2 rst = 1;
    #1;
    check("t6_valid", 32'(ovalid), 0);
    check("t6_byte", 32'(obyte), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_rd", 32'(fifo_rd), 0);
    check("t6_counts", {8'h0, bytes_sent} | {8'h0, entries}, 0);
    exp_q.delete();
    push_exp(C_DATA, 16'h0004, 8'h22);
    tick(); tick();
    rst = 0;
    ready = 1;
    wait_drain("t6");
    check("t6_entries", 32'(entries), 1);
    check("t6_bytes", 32'(bytes_sent), 2);

    // Checksum: TIME 16'h0FF0 gives bytes 8'h40, 8'h0F, 8'hF0
    clr();
    check("t7_csum_clr", 32'(csum), 0);
    push_entry(C_TIME, 16'h0FF0, 8'h00);
    wait_drain("t7");
`ifdef FE_READER_CHECKSUM_EN
    check("t7_csum", 32'(csum), 32'(cs_model));
    check("t7_csum_lit", 32'(csum), 32'(8'h40 ^ 8'hFF));
`else
    check("t7_csum_off", 32'(csum), 0);
`endif
    check("t7_bytes", 32'(bytes_sent), 3);
    check("t7_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
